fifo_thresh: RTL and testbench

FIFO_THRESH -- requirements
Module: fifo_thresh

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_thresh.sv | 142 ++++++++++++++
 tb/tb_fifo_thresh.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the threshold FIFO: read-mode selectors and the
// level/pointer width helper.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointers and level carry one extra bit so that "full" (level == depth) is representable.
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_thresh: one synchronous write port and one
// asynchronous read port. The contents are not reset.
module fifo_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with programmable almost-full/almost-empty flags, a
// registered or first-word-fall-through read, and optional sticky error flags
// (macro FIFO_THRESH_ERR_FLAGS_EN).
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int FWFT   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  output logic              fifo_full,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   level,
  input  logic [ADDR_W:0]   afull_thresh,
  input  logic [ADDR_W:0]   aempty_thresh,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int LW    = level_w(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;

  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_fire, rd_fire;

  // Handshake: a write transfers on an edge where write_en=1 and fifo_full=0;
  // a read transfers on an edge where read_en=1 and fifo_empty=0. A request
  // made against the opposite condition is dropped and changes no state.
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign wr_fire    = write_en && !fifo_full && reset_n;
  assign rd_fire    = read_en && !fifo_empty && reset_n;

  assign level        = level_q;
  assign almost_full  = (level_q >= afull_thresh);
  assign almost_empty = (level_q <= aempty_thresh);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + LW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + LW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  fifo_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head entry is visible straight from the array; meaningless while empty.
      assign data_out = ram_rdata;
    end else begin : g_reg_read
      logic [DATA_W-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_fire) dout_d = ram_rdata;
      end

      always_ff @(posedge clock) begin
        if (!reset_n) dout_q <= '0;
        else          dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

`ifdef FIFO_THRESH_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A new error event takes priority over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_en && fifo_full)  ovf_d = 1'b1;
    if (read_en  && fifo_empty) unf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: a registered-read and a fall-through instance share
// stimulus; read data is checked against expected queues by monitors.
module tb_fifo_thresh;

`ifdef FIFO_THRESH_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic [7:0] data_in;
  logic       write_en;
  logic       read_en;
  logic       err_clr;
  logic [2:0] afull_thresh;
  logic [2:0] aempty_thresh;

  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [7:0] dout0;
  logic [2:0] level0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [7:0] dout1;
  logic [2:0] level1;

  logic [7:0] exp_q[$];
  logic [7:0] exp_fw_q[$];
  logic       fire0_q;
  int         n_checks;
  int         n_fail;

  fifo_thresh #(.ADDR_W(2), .DATA_W(8), .FWFT(0)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .write_en(write_en),
    .fifo_full(full0), .read_en(read_en), .data_out(dout0), .fifo_empty(empty0),
    .level(level0), .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0),
    .err_clr(err_clr)
  );

  fifo_thresh #(.ADDR_W(2), .DATA_W(8), .FWFT(1)) dut_fw (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .write_en(write_en),
    .fifo_full(full1), .read_en(read_en), .data_out(dout1), .fifo_empty(empty1),
    .level(level1), .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1),
    .err_clr(err_clr)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor, registered read: data appears the cycle after an accepted read
  initial fire0_q = 1'b0;
  always @(posedge clock) fire0_q <= reset_n && read_en && !empty0;

  always @(negedge clock) begin
    if (fire0_q) begin
      if (exp_q.size() == 0) check("reg_read_unexpected", 32'(dout0), 32'hFFFF_FFFF);
      else check("reg_read_data", 32'(dout0), 32'(exp_q.pop_front()));
    end
  end

  // Monitor, fall-through: head is presented while the FIFO is not empty
  always @(negedge clock) begin
    if (reset_n && read_en && !empty1) begin
      if (exp_fw_q.size() == 0) check("fwft_read_unexpected", 32'(dout1), 32'hFFFF_FFFF);
      else check("fwft_read_data", 32'(dout1), 32'(exp_fw_q.pop_front()));
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    write_en = w;
    data_in  = d;
    read_en  = r;
    err_clr  = c;
    @(posedge clock);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic push_write(input logic [7:0] d);
    exp_q.push_back(d);
    exp_fw_q.push_back(d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic check_both(input string name, input logic [2:0] lvl, input logic emp,
                            input logic ful, input logic a_f, input logic a_e);
    check({name, "_level"},  32'(level0), 32'(lvl));
    check({name, "_empty"},  32'(empty0), 32'(emp));
    check({name, "_full"},   32'(full0),  32'(ful));
    check({name, "_afull"},  32'(af0),    32'(a_f));
    check({name, "_aempty"}, 32'(ae0),    32'(a_e));
    check({name, "_fw_level"}, 32'(level1), 32'(lvl));
    check({name, "_fw_empty"}, 32'(empty1), 32'(emp));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    data_in       = 8'h00;
    write_en      = 1'b0;
    read_en       = 1'b0;
    err_clr       = 1'b0;
    afull_thresh  = 3'd3;
    aempty_thresh = 3'd1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state
    check_both("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_dout", 32'(dout0), 32'h0);
    check("reset_ovf", 32'(ovf0), 32'h0);
    check("reset_unf", 32'(unf0), 32'h0);

    // Fill to full, watching thresholds
    push_write(8'h11); check_both("fill1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_write(8'h22); check_both("fill2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    push_write(8'h33); check_both("fill3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    push_write(8'h44); check_both("fill4", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);

    // Write while full is dropped
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    check_both("ovf_write", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_set", 32'(ovf0), 32'(ERR));
    check("ovf_set_fw", 32'(ovf1), 32'(ERR));

    // Drain: data order checked by the monitors
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_both("drained", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("dout_hold", 32'(dout0), 32'h44);

    // Read while empty is dropped
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_both("unf_read", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("unf_set", 32'(unf0), 32'(ERR));
    check("ovf_sticky", 32'(ovf0), 32'(ERR));
    check("dout_hold_unf", 32'(dout0), 32'h44);

    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf0), 32'h0);
    check("unf_cleared", 32'(unf0), 32'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    check("unf_set_beats_clr", 32'(unf0), 32'(ERR));
    check("ovf_stays_clear", 32'(ovf0), 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_cleared2", 32'(unf0), 32'h0);

    // Fall-through: head visible with no read request
    push_write(8'hA5);
    check("fwft_head", 32'(dout1), 32'hA5);
    check("fwft_not_empty", 32'(empty1), 32'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_both("fwft_pop", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Concurrent write+read at level 2 across pointer wrap
    push_write(8'h50);
    push_write(8'h51);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'h52 + 8'(i));
      exp_fw_q.push_back(8'h52 + 8'(i));
      drive(1'b1, 8'h52 + 8'(i), 1'b1, 1'b0);
      check_both("concurrent", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_both("wrap_drained", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("wrap_last", 32'(dout0), 32'h57);

    // Reset mid-operation at level 3
    push_write(8'h61);
    push_write(8'h62);
    push_write(8'h63);
    check_both("pre_reset", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    exp_fw_q.delete();
    reset_n = 1'b0;
    drive(1'b1, 8'h64, 1'b1, 1'b0);
    reset_n = 1'b1;
    check_both("mid_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_reset_dout", 32'(dout0), 32'h0);
    push_write(8'h77);
    check("post_reset_fw_head", 32'(dout1), 32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_both("post_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_reset_dout", 32'(dout0), 32'h77);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("exp_fw_q_drained", 32'(exp_fw_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
